hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline-control responder to the forwarding unit's override requests (hu_override_ex/mem/wb).
- Decides per cycle, for IF/ID, ID/EX, EX/MEM and MEM/WB, whether each pipeline register advances, holds or is flushed.
- Sequences load-use bubbles, data-memory wait stalls, EX-stage redirects and halt.
- Sits beside the datapath and drives the enable/flush inputs of all pipeline registers and the PC.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- hu_override_ex  in  1  forwarding unit resolves the EX/ID dependency; suppresses load-use bubble.
- hu_override_mem  in  1  reserved; no effect.
- hu_override_wb  in  1  reserved; no effect.
- opcode_ex  in  6  opcode_t of the EX instruction.
- wen_ex  in  1  EX instruction writes the register file.
- wsel_ex  in  5  EX destination register.
- id_rsel1, id_rsel2  in  5 each  ID source registers.
- dmemREN_mem, dmemWEN_mem  in  1 each  MEM-stage data access request.
- dhit  in  1  data access completes this cycle.
- ihit  in  1  instruction fetch completes this cycle.
- branch_taken_ex  in  1  taken branch resolved in EX.
- jump_ex  in  1  J/JAL/JR resolved in EX.
- halt_wb  in  1  HALT instruction in WB.
- pc_en  out  1  PC loads next value.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register advances.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register loads a bubble (NOP, wen=0).
- halt  out  1  sticky halt indication.
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.

Behaviour:
- FSM states: RUN, LU_STALL, DMEM_WAIT, HALTED. Registered state, stall_cnt and halt. All other outputs are combinational from state and inputs.
- While RST=1: every *_en=0, every *_flush=1, pc_en=0, halt=0. At the next edge: state=RUN, stall_cnt=0.
- Defaults, when no condition below fires: all *_en=1, all flushes=0, pc_en=1.
- A flush overrides its register's en (flush=1 implies the register loads a bubble).
- Conditions are applied in the following priority order, highest first.
- HALTED:
  - Entered from any state on halt_wb=1; the registered halt goes to 1 at the same edge.
  - In HALTED: all en=0, flushes=0, pc_en=0, halt=1, stall_cnt frozen.
  - Left only by RST.
- Memory wait (mem_pend = dmemREN_mem|dmemWEN_mem):
  - If mem_pend=1 and dhit=0: pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1; next state DMEM_WAIT.
  - Applies in RUN, LU_STALL and DMEM_WAIT.
  - In DMEM_WAIT with dhit=1: defaults apply; next state RUN.
- Redirect (branch_taken_ex|jump_ex, no memory wait):
  - pc_en=1 regardless of ihit; ifid_flush=1; idex_flush=1; next state RUN.
  - Overrides load-use and ihit stall.
- Load-use, evaluated in RUN only:
  - Fires when opcode_ex is LW or LL, wen_ex=1, wsel_ex!=0, wsel_ex equals id_rsel1 or id_rsel2, and hu_override_ex=0.
  - Action: pc_en=0, ifid_en=0, idex_flush=1; next state LU_STALL.
  - LU_STALL lasts exactly one cycle. Load-use detection is masked there (no double bubble). Next state RUN unless a higher-priority condition fires.
- Ifetch miss (ihit=0, nothing above):
  - pc_en=0, ifid_flush=1; later stages advance.
- stall_cnt: increments at each edge where pc_en=0 and state!=HALTED and RST=0; saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events: halt_wb beats everything. Memory wait beats redirect; the redirect is re-presented next cycle because EX is held. Redirect beats load-use.

Test Plan:
- RST high 2 cycles, then low → all flushes=1 during reset; after release state RUN, pc_en=1, stall_cnt=0, halt=0.
- opcode_ex=LW, wen_ex=1, wsel_ex=5, id_rsel1=5, hu_override_ex=0, ihit=1 → cycle 0: pc_en=0, ifid_en=0, idex_flush=1; cycle 1 (same inputs): defaults, no second bubble; stall_cnt=1.
- Same as above but hu_override_ex=1 → no stall; pc_en=1 throughout; stall_cnt stays 0.
- dmemREN_mem=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with pc_en/ifid/idex/exmem en=0 and memwb_flush=1; cycle 4 all advance; stall_cnt=3.
- branch_taken_ex=1 with ihit=0 and a load-use match → pc_en=1, ifid_flush=1, idex_flush=1, no load-use bubble; stall_cnt unchanged.
- halt_wb=1 while dmemREN_mem=1, dhit=0 → next cycle halt=1, all en=0, stall_cnt frozen; stays halted 10+ cycles until RST.
- CNT_W=4 with ihit=0 held 20 cycles → stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush sequencer.
// Resolves load-use bubbles, data-memory wait stalls, EX-stage redirects and
// halt into per-register advance/flush controls plus the PC load enable.
// State, halt and the stall-cycle counter are registered; the control outputs
// are combinational from the current state and inputs so that the pipeline
// reacts in the same cycle as the hazard is seen.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hu_override_ex,
  input  logic             hu_override_mem,
  input  logic             hu_override_wb,
  input  logic [5:0]       opcode_ex,
  input  logic             wen_ex,
  input  logic [4:0]       wsel_ex,
  input  logic [4:0]       id_rsel1,
  input  logic [4:0]       id_rsel2,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_taken_ex,
  input  logic             jump_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_STALL  = 2'd1;
  localparam logic [1:0] ST_DMEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LL = 6'b110000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             halt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             mem_wait_s;
  logic             redirect_s;
  logic             load_use_s;
  logic             unused_s;

  // A load in EX whose destination is read by the ID instruction, unless the
  // forwarding unit has already taken care of the dependency.
  function automatic logic load_use_hit(
    input logic [5:0] op,
    input logic       wen,
    input logic [4:0] wsel,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       fwd_override
  );
    logic is_load;
    is_load = (op == OP_LW) || (op == OP_LL);
    return is_load && wen && (wsel != 5'd0) &&
           ((wsel == rs1) || (wsel == rs2)) && !fwd_override;
  endfunction

  // The MEM/WB override requests are reserved and intentionally ignored.
  assign unused_s = hu_override_mem ^ hu_override_wb;

  assign mem_wait_s = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign redirect_s = branch_taken_ex | jump_ex;
  assign load_use_s = load_use_hit(opcode_ex, wen_ex, wsel_ex, id_rsel1,
                                   id_rsel2, hu_override_ex);

  assign halt      = halt_r & ~RST;
  assign stall_cnt = stall_cnt_r;

  // Prioritised hazard resolution: reset, halt, memory wait, redirect,
  // load-use (RUN only), ifetch miss, then normal advance.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_nxt_s = ST_RUN;
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_nxt_s = ST_RUN;
    end else if ((state_r == ST_HALTED) || halt_wb) begin
      // Freeze the whole pipeline without inserting bubbles.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      state_nxt_s = ST_HALTED;
    end else if (mem_wait_s) begin
      // Hold everything up to EX/MEM; WB retires a bubble meanwhile. A
      // redirect in EX is held too and gets re-presented next cycle.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_nxt_s = ST_DMEM_WAIT;
    end else if (redirect_s) begin
      // Wrong-path IF and ID instructions are squashed; PC takes the target
      // even while the fetch is still outstanding.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_nxt_s = ST_RUN;
    end else if ((state_r == ST_RUN) && load_use_s) begin
      // One bubble into EX; the dependent instruction waits in ID.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
      state_nxt_s = ST_LU_STALL;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      state_nxt_s = ST_RUN;
    end else begin
      state_nxt_s = ST_RUN;
    end
  end

  // State, sticky halt and saturating stall-cycle counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_RUN;
      halt_r      <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      halt_r  <= (state_nxt_s == ST_HALTED);
      if (!pc_en && (state_r != ST_HALTED) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the stall rules.
module tb_hazard_unit;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LL   = 6'b110000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST, hu_override_ex, hu_override_mem, hu_override_wb;
  logic [5:0] opcode_ex;
  logic wen_ex;
  logic [4:0] wsel_ex, id_rsel1, id_rsel2;
  logic dmemREN_mem, dmemWEN_mem, dhit, ihit, branch_taken_ex, jump_ex, halt_wb;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [15:0] stall_cnt;
  logic b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en;
  logic b_ifid_flush, b_idex_flush, b_exmem_flush, b_memwb_flush, b_halt;
  logic [3:0] b_stall_cnt;

  hazard_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .hu_override_ex(hu_override_ex),
    .hu_override_mem(hu_override_mem), .hu_override_wb(hu_override_wb),
    .opcode_ex(opcode_ex), .wen_ex(wen_ex), .wsel_ex(wsel_ex),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .dmemREN_mem(dmemREN_mem),
    .dmemWEN_mem(dmemWEN_mem), .dhit(dhit), .ihit(ihit),
    .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .hu_override_ex(hu_override_ex),
    .hu_override_mem(hu_override_mem), .hu_override_wb(hu_override_wb),
    .opcode_ex(opcode_ex), .wen_ex(wen_ex), .wsel_ex(wsel_ex),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .dmemREN_mem(dmemREN_mem),
    .dmemWEN_mem(dmemWEN_mem), .dhit(dhit), .ihit(ihit),
    .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex), .halt_wb(halt_wb),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
    .exmem_en(b_exmem_en), .memwb_en(b_memwb_en), .ifid_flush(b_ifid_flush),
    .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush),
    .memwb_flush(b_memwb_flush), .halt(b_halt), .stall_cnt(b_stall_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model state: what the pipeline is currently doing, in plain flags.
  bit m_halted = 1'b0;
  bit m_bubble_done = 1'b0;  // previous cycle inserted a load-use bubble
  bit m_waiting = 1'b0;      // previous cycle was stalled on data memory
  int m_cnt = 0;
  int m_cnt4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, halt}.
  function automatic logic [9:0] model_out();
    bit lu, in_run, mwait;
    lu = (opcode_ex == OP_LW || opcode_ex == OP_LL) && wen_ex && wsel_ex != 5'd0 &&
         (wsel_ex == id_rsel1 || wsel_ex == id_rsel2) && !hu_override_ex;
    in_run = !m_halted && !m_bubble_done && !m_waiting;
    mwait = (dmemREN_mem || dmemWEN_mem) && !dhit;
    if (RST)                            return 10'b0_0000_1111_0;
    if (m_halted || halt_wb)            return {9'b0_0000_0000, m_halted};
    if (mwait)                          return 10'b0_0001_0001_0;
    if (branch_taken_ex || jump_ex)     return 10'b1_1111_1100_0;
    if (in_run && lu)                   return 10'b0_0111_0100_0;
    if (!ihit)                          return 10'b0_1111_1000_0;
    return 10'b1_1111_0000_0;
  endfunction

  task automatic model_step(input bit exp_pc_en);
    bit lu, in_run;
    lu = (opcode_ex == OP_LW || opcode_ex == OP_LL) && wen_ex && wsel_ex != 5'd0 &&
         (wsel_ex == id_rsel1 || wsel_ex == id_rsel2) && !hu_override_ex;
    in_run = !m_halted && !m_bubble_done && !m_waiting;
    if (RST) begin
      m_halted = 0; m_bubble_done = 0; m_waiting = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (!m_halted && !exp_pc_en) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_halted || halt_wb) begin
        m_halted = 1; m_bubble_done = 0; m_waiting = 0;
      end else if ((dmemREN_mem || dmemWEN_mem) && !dhit) begin
        m_waiting = 1; m_bubble_done = 0;
      end else if (!branch_taken_ex && !jump_ex && in_run && lu) begin
        m_bubble_done = 1; m_waiting = 0;
      end else begin
        m_bubble_done = 0; m_waiting = 0;
      end
    end
  endtask

  task automatic cycle();
    logic [9:0] exp;
    @(negedge CLK);
    exp = model_out();
    chk("ctl", {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                idex_flush, exmem_flush, memwb_flush, halt}, {22'd0, exp});
    chk("ctl4", {22'd0, b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en,
                 b_ifid_flush, b_idex_flush, b_exmem_flush, b_memwb_flush, b_halt},
        {22'd0, exp});
    chk("cnt", {16'd0, stall_cnt}, m_cnt);
    chk("cnt4", {28'd0, b_stall_cnt}, m_cnt4);
    @(posedge CLK);
    model_step(exp[9]);
    #1;
  endtask

  task automatic set_idle();
    RST = 0; hu_override_ex = 0; hu_override_mem = 0; hu_override_wb = 0;
    opcode_ex = OP_ADDI; wen_ex = 0; wsel_ex = 5'd0; id_rsel1 = 5'd0; id_rsel2 = 5'd0;
    dmemREN_mem = 0; dmemWEN_mem = 0; dhit = 0; ihit = 1;
    branch_taken_ex = 0; jump_ex = 0; halt_wb = 0;
  endtask

  task automatic do_reset();
    set_idle();
    RST = 1;
    repeat (2) cycle();
    RST = 0;
  endtask

  task automatic set_load_use();
    opcode_ex = OP_LW; wen_ex = 1; wsel_ex = 5'd5; id_rsel1 = 5'd5; id_rsel2 = 5'd9;
  endtask

  initial begin
    set_idle();
    RST = 1;
    #1;
    // Reset: all flushes during reset, clean RUN afterwards.
    repeat (2) cycle();
    chk("rst_flush", {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'hF);
    RST = 0;
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    cycle();

    // Load-use: exactly one bubble.
    do_reset();
    set_load_use();
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    repeat (2) cycle();
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load-use with forwarding override: no stall.
    do_reset();
    set_load_use();
    hu_override_ex = 1;
    repeat (3) cycle();
    chk("ovr_cnt", {16'd0, stall_cnt}, 32'd0);

    // Data memory wait for three cycles.
    do_reset();
    dmemREN_mem = 1; dhit = 0;
    repeat (3) cycle();
    dhit = 1;
    #1;
    chk("dmem_done_exmem_en", {31'd0, exmem_en}, 32'd1);
    cycle();
    chk("dmem_cnt", {16'd0, stall_cnt}, 32'd3);

    // Redirect beats ifetch miss and load-use.
    do_reset();
    set_load_use();
    branch_taken_ex = 1; ihit = 0;
    #1;
    chk("redir_vec", {29'd0, pc_en, ifid_flush, idex_flush}, 32'h7);
    cycle();
    chk("redir_cnt", {16'd0, stall_cnt}, 32'd0);

    // Halt during a memory wait: sticky until reset, counter frozen.
    do_reset();
    dmemREN_mem = 1; dhit = 0; halt_wb = 1;
    cycle();
    set_idle();
    repeat (12) cycle();
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    chk("halt_cnt", {16'd0, stall_cnt}, 32'd1);

    // Counter saturation on the 4-bit instance.
    do_reset();
    ihit = 0;
    repeat (20) cycle();
    chk("sat_cnt4", {28'd0, b_stall_cnt}, 32'd15);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd20);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] opsel;
      RST = ($urandom_range(0, 59) == 0);
      halt_wb = ($urandom_range(0, 79) == 0);
      hu_override_ex = ($urandom_range(0, 3) == 0);
      hu_override_mem = 1'($urandom);
      hu_override_wb = 1'($urandom);
      opsel = 2'($urandom);
      case (opsel)
        2'd0: opcode_ex = OP_LW;
        2'd1: opcode_ex = OP_LL;
        2'd2: opcode_ex = OP_SW;
        default: opcode_ex = OP_ADDI;
      endcase
      wen_ex = ($urandom_range(0, 3) != 0);
      wsel_ex = 5'($urandom_range(0, 3));
      id_rsel1 = 5'($urandom_range(0, 3));
      id_rsel2 = 5'($urandom_range(0, 3));
      dmemREN_mem = ($urandom_range(0, 4) == 0);
      dmemWEN_mem = ($urandom_range(0, 7) == 0);
      dhit = 1'($urandom);
      ihit = ($urandom_range(0, 4) != 0);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      jump_ex = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
